// File: rtl/reg_file_wb_pkg.sv
// Shared processor definitions for the register file and its writeback buffer.
package reg_file_wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned MAX_DEPTH  = 4;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned CNT_W      = 3;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // Advance a circular pointer, wrapping at depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                               input logic [CNT_W-1:0] depth);
    if (({1'b0, p} + 3'd1) == depth) return '0;
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/wbFifo.sv
// Writeback buffer: circular FIFO that retires its head every cycle it is non-empty and
// exposes all slots so the register file can bypass pending writes to its read ports.
module wbFifo
  import reg_file_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  wb_entry_t                   push_entry,
  output logic                        ready,
  output logic                        empty,
  output wb_entry_t                   head_entry,
  output logic [PTR_W-1:0]            head,
  output logic [CNT_W-1:0]            count,
  output wb_entry_t [MAX_DEPTH-1:0]   entries
);

  localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);

  wb_entry_t [MAX_DEPTH-1:0] entries_q;
  logic [PTR_W-1:0]          head_q, tail_q;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      pop;

  assign pop        = (count_q != '0);
  assign ready      = (count_q < DepthC);
  assign empty      = (count_q == '0);
  assign head_entry = entries_q[head_q];
  assign head       = head_q;
  assign count      = count_q;
  assign entries    = entries_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        entries_q[tail_q] <= push_entry;
        tail_q            <= ptr_inc(tail_q, DepthC);
      end
      if (pop) head_q <= ptr_inc(head_q, DepthC);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// 32x32 register file whose writes go through a small writeback buffer; reads see the
// youngest pending write to an address before it reaches the array.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] A1,
  input  logic [REG_ADDR_W-1:0] A2,
  output logic [XLEN-1:0]       RD1,
  output logic [XLEN-1:0]       RD2,
  input  logic                  wbValid,
  output logic                  wbReady,
  input  logic [REG_ADDR_W-1:0] A3,
  input  logic [XLEN-1:0]       WD3,
  output logic                  wbEmpty
);

  localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);

  logic [XLEN-1:0]           regs_q [NUM_REGS];
  logic                      push;
  wb_entry_t                 push_entry;
  wb_entry_t                 head_entry;
  logic [PTR_W-1:0]          head;
  logic [CNT_W-1:0]          count;
  wb_entry_t [MAX_DEPTH-1:0] entries;
  logic [CNT_W-1:0]          slot;

  // Writes to x0 complete the handshake but never enter the buffer.
  assign push       = wbValid && wbReady && (A3 != '0);
  assign push_entry = '{rd: A3, data: WD3};

  wbFifo #(
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .ready      (wbReady),
    .empty      (wbEmpty),
    .head_entry (head_entry),
    .head       (head),
    .count      (count),
    .entries    (entries)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (!wbEmpty) begin
      regs_q[head_entry.rd] <= head_entry.data;
    end
  end

  // Walk pending entries oldest to youngest so the youngest match wins.
  always_comb begin
    RD1  = regs_q[A1];
    RD2  = regs_q[A2];
    slot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = {1'b0, head} + CNT_W'(i);
      if (slot >= DepthC) slot = slot - DepthC;
      if (CNT_W'(i) < count) begin
        if (entries[slot[PTR_W-1:0]].rd == A1) RD1 = entries[slot[PTR_W-1:0]].data;
        if (entries[slot[PTR_W-1:0]].rd == A2) RD2 = entries[slot[PTR_W-1:0]].data;
      end
    end
    if (A1 == '0) RD1 = '0;
    if (A2 == '0) RD2 = '0;
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Randomised and directed bench for reg_file_wb against a queue-based behavioural model.
module tb_reg_file_wb;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  A1 = '0, A2 = '0, A3 = '0;
  logic [31:0] WD3 = '0;
  logic        wbValid = 1'b0;
  logic [31:0] RD1, RD2;
  logic        wbReady, wbEmpty;

  reg_file_wb #(
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .A1      (A1),
    .A2      (A2),
    .RD1     (RD1),
    .RD2     (RD2),
    .wbValid (wbValid),
    .wbReady (wbReady),
    .A3      (A3),
    .WD3     (WD3),
    .wbEmpty (wbEmpty)
  );

  always #5 clk = ~clk;

  // Model: committed array plus an ordered list of pending writes.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        pend[$];
  logic [31:0] arr[32];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          chk_en   = 1'b0;
  int          x0_accepts = 0;

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0) return 32'd0;
    v = arr[a];
    foreach (pend[i]) if (pend[i].rd == a) v = pend[i].d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      pend.delete();
      for (int i = 0; i < 32; i++) arr[i] = 32'd0;
      chk_en = 1'b1;
    end else begin
      bit acc;
      acc = wbValid && (pend.size() < DEPTH);
      if (pend.size() > 0) begin
        arr[pend[0].rd] = pend[0].d;
        void'(pend.pop_front());
      end
      if (acc && A3 != 5'd0) pend.push_back('{rd: A3, d: WD3});
      if (acc && A3 == 5'd0) x0_accepts++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rd1", RD1, model_rd(A1));
      chk("model_rd2", RD2, model_rd(A2));
      chk("model_ready", {31'd0, wbReady}, {31'd0, pend.size() < DEPTH});
      chk("model_empty", {31'd0, wbEmpty}, {31'd0, pend.size() == 0});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vals[DEPTH+2];

  initial begin
    int x0_before;
    step();
    step();
    reset = 1'b0;

    // Post-reset: every register reads zero.
    for (int a = 1; a < 32; a++) begin
      A1 = 5'(a);
      A2 = 5'(32 - a);
      @(negedge clk);
      chk("reset_rd1", RD1, 32'd0);
      chk("reset_rd2", RD2, 32'd0);
      step();
    end
    chk("reset_ready", {31'd0, wbReady}, 32'd1);
    chk("reset_empty", {31'd0, wbEmpty}, 32'd1);

    // x5 write: not visible before acceptance, visible after, drained one cycle later.
    wbValid = 1'b1; A3 = 5'd5; WD3 = 32'hDEADBEEF; A1 = 5'd5;
    @(negedge clk);
    chk("x5_no_bypass", RD1, 32'd0);
    chk("x5_ready", {31'd0, wbReady}, 32'd1);
    step();
    wbValid = 1'b0;
    @(negedge clk);
    chk("x5_visible", RD1, 32'hDEADBEEF);
    chk("x5_pending", {31'd0, wbEmpty}, 32'd0);
    step();
    @(negedge clk);
    chk("x5_committed_empty", {31'd0, wbEmpty}, 32'd1);
    chk("x5_committed_rd", RD1, 32'hDEADBEEF);

    // x0 write is swallowed.
    step();
    x0_before = x0_accepts;
    wbValid = 1'b1; A3 = 5'd0; WD3 = 32'h12345678; A2 = 5'd0;
    @(negedge clk);
    chk("x0_ready", {31'd0, wbReady}, 32'd1);
    step();
    wbValid = 1'b0;
    @(negedge clk);
    chk("x0_rd2", RD2, 32'd0);
    chk("x0_empty", {31'd0, wbEmpty}, 32'd1);
    chk("x0_handshake", x0_accepts - x0_before, 32'd1);

    // Back-to-back writes to x7.
    step();
    wbValid = 1'b1; A3 = 5'd7; WD3 = 32'd1; A1 = 5'd7;
    step();
    WD3 = 32'd2;
    @(negedge clk);
    chk("x7_first", RD1, 32'd1);
    step();
    wbValid = 1'b0;
    @(negedge clk);
    chk("x7_second", RD1, 32'd2);
    step();
    step();
    @(negedge clk);
    chk("x7_final", RD1, 32'd2);
    chk("x7_empty", {31'd0, wbEmpty}, 32'd1);

    // Sustained stream of DEPTH+2 writes never stalls.
    for (int k = 0; k < DEPTH + 2; k++) begin
      step();
      vals[k] = $urandom;
      wbValid = 1'b1; A3 = 5'(10 + k); WD3 = vals[k];
      @(negedge clk);
      chk("stream_ready", {31'd0, wbReady}, 32'd1);
    end
    step();
    wbValid = 1'b0;
    step();
    for (int k = 0; k < DEPTH + 2; k++) begin
      step();
      A1 = 5'(10 + k);
      A2 = 5'(10 + k);
      @(negedge clk);
      chk("stream_rd1", RD1, vals[k]);
      chk("stream_rd2", RD2, vals[k]);
    end

    // Reset with x9 still pending.
    step();
    wbValid = 1'b1; A3 = 5'd9; WD3 = 32'hAA; A1 = 5'd9;
    step();
    wbValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("x9_pending_rd", RD1, 32'hAA);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("x9_after_reset", RD1, 32'd0);
    chk("x9_empty", {31'd0, wbEmpty}, 32'd1);
    chk("x7_after_reset", model_rd(5'd7), 32'd0);

    // Random traffic on a few registers, with occasional resets during handshakes.
    for (int n = 0; n < 600; n++) begin
      step();
      reset   = ($urandom_range(0, 49) == 0);
      wbValid = 1'($urandom_range(0, 1));
      A3      = 5'($urandom_range(0, 7));
      WD3     = $urandom;
      A1      = 5'($urandom_range(0, 7));
      A2      = 5'($urandom_range(0, 7));
    end
    step();
    reset = 1'b0; wbValid = 1'b0;
    step();
    step();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
